// File: rtl/wb_sdram_arbiter.sv
// ---------------------------------------------------------------------------
// wb_sdram_arbiter
//
// Two-master round-robin arbiter in front of the single Wishbone slave port
// of the SDRAM controller. A grant is held for the whole cyc tenure of the
// owning master, so incrementing bursts are never split. Arbitration takes
// one cycle, and the slave-side mux is driven combinationally from the
// registered grant.
//
// Parameters:
//   dw      - data width
//   aw      - address width
//   TIMEOUT - stalled cycles before a forced release (watchdog builds only)
//
// Ports:
//   sys_clk, sys_rst       - clock; asynchronous active-high reset
//   m0_* / m1_*            - requester ports: cyc/stb/we/addr/dat/sel/cti in,
//                            ack/err/dat out
//   s_*                    - controller port: cyc/stb/we/addr/dat/sel/cti out,
//                            ack/dat in
//   gnt_o                  - one-hot current grant {GNT1, GNT0}
//
// Optional build macro:
//   WB_ARB_TIMEOUT_EN      - adds an 8-bit watchdog. When the granted master
//                            stalls for TIMEOUT cycles with no ack, its err
//                            output pulses and the grant is released.
//                            Without it, m*_err_o are tied to 0.
// ---------------------------------------------------------------------------
module wb_sdram_arbiter #(
    parameter int dw      = 32,
    parameter int aw      = 26,
    parameter int TIMEOUT = 64
) (
    input  logic            sys_clk,
    input  logic            sys_rst,

    input  logic            m0_cyc_i,
    input  logic            m0_stb_i,
    input  logic            m0_we_i,
    input  logic [aw-1:0]   m0_addr_i,
    input  logic [dw-1:0]   m0_dat_i,
    input  logic [dw/8-1:0] m0_sel_i,
    input  logic [2:0]      m0_cti_i,
    output logic            m0_ack_o,
    output logic            m0_err_o,
    output logic [dw-1:0]   m0_dat_o,

    input  logic            m1_cyc_i,
    input  logic            m1_stb_i,
    input  logic            m1_we_i,
    input  logic [aw-1:0]   m1_addr_i,
    input  logic [dw-1:0]   m1_dat_i,
    input  logic [dw/8-1:0] m1_sel_i,
    input  logic [2:0]      m1_cti_i,
    output logic            m1_ack_o,
    output logic            m1_err_o,
    output logic [dw-1:0]   m1_dat_o,

    output logic            s_cyc_o,
    output logic            s_stb_o,
    output logic            s_we_o,
    output logic [aw-1:0]   s_addr_o,
    output logic [dw-1:0]   s_dat_o,
    output logic [dw/8-1:0] s_sel_o,
    output logic [2:0]      s_cti_o,
    input  logic            s_ack_i,
    input  logic [dw-1:0]   s_dat_i,

    output logic [1:0]      gnt_o
);

    // The watchdog counter is 8 bits wide, so TIMEOUT must fit in it.
    if (TIMEOUT < 1 || TIMEOUT > 256) begin : g_bad_timeout
        $error("wb_sdram_arbiter: TIMEOUT must be in 1..256");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } state_t;

    state_t state;
    logic   last_gnt;   // master granted most recently; the loser of a tie
    logic   sel0;
    logic   sel1;
    logic   timeout;    // watchdog release of the current owner

    assign sel0  = (state == GNT0);
    assign sel1  = (state == GNT1);
    // The grant is decoded from the registered state only, so there is no
    // combinational path from the cyc inputs.
    assign gnt_o = {sel1, sel0};

    // Slave-side mux. Gating cyc with the registered grant guarantees at
    // least one cycle of s_cyc_o low whenever ownership changes.
    always_comb begin
        // NOTE: every output gets a default first, so no path through this
        // block can leave a value unassigned and infer a latch.
        s_cyc_o  = 1'b0;
        s_stb_o  = 1'b0;
        s_we_o   = 1'b0;
        s_addr_o = '0;
        s_dat_o  = '0;
        s_sel_o  = '0;
        s_cti_o  = '0;
        if (sel0) begin
            s_cyc_o  = m0_cyc_i;
            s_stb_o  = m0_stb_i;
            s_we_o   = m0_we_i;
            s_addr_o = m0_addr_i;
            s_dat_o  = m0_dat_i;
            s_sel_o  = m0_sel_i;
            s_cti_o  = m0_cti_i;
        end else if (sel1) begin
            s_cyc_o  = m1_cyc_i;
            s_stb_o  = m1_stb_i;
            s_we_o   = m1_we_i;
            s_addr_o = m1_addr_i;
            s_dat_o  = m1_dat_i;
            s_sel_o  = m1_sel_i;
            s_cti_o  = m1_cti_i;
        end
    end

    // Only the owner ever sees an ack. Read data is broadcast to both
    // masters, because a master only looks at it alongside its own ack.
    assign m0_ack_o = s_ack_i & sel0;
    assign m1_ack_o = s_ack_i & sel1;
    assign m0_dat_o = s_dat_i;
    assign m1_dat_o = s_dat_i;

`ifdef WB_ARB_TIMEOUT_EN
    logic [7:0] wdt;
    logic       leaving;

    // The owner is dropping cyc, so the state will change at the next edge.
    assign leaving = (sel0 & ~m0_cyc_i) | (sel1 & ~m1_cyc_i);
    assign timeout = (state != IDLE) & s_stb_o & ~s_ack_i &
                     (wdt == 8'(TIMEOUT - 1));
    assign m0_err_o = timeout & sel0;
    assign m1_err_o = timeout & sel1;

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            wdt <= '0;
        end else if (state == IDLE || s_ack_i || leaving || timeout) begin
            wdt <= '0;
        end else if (s_stb_o) begin
            wdt <= wdt + 8'd1;
        end
    end
`else
    assign timeout  = 1'b0;
    assign m0_err_o = 1'b0;
    assign m1_err_o = 1'b0;
`endif

    // Grant FSM. A timeout release leaves last_gnt pointing at the errored
    // master, so the other master wins the next contention.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        // NOTE: state registers use non-blocking assignments, so every
        // branch reads the values from before this edge.
        if (sys_rst) begin
            state    <= IDLE;
            last_gnt <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (m0_cyc_i && (!m1_cyc_i || last_gnt)) begin
                        state    <= GNT0;
                        last_gnt <= 1'b0;
                    end else if (m1_cyc_i) begin
                        state    <= GNT1;
                        last_gnt <= 1'b1;
                    end
                end
                GNT0: begin
                    if (timeout) begin
                        state <= IDLE;
                    end else if (!m0_cyc_i) begin
                        if (m1_cyc_i) begin
                            state    <= GNT1;
                            last_gnt <= 1'b1;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                GNT1: begin
                    if (timeout) begin
                        state <= IDLE;
                    end else if (!m1_cyc_i) begin
                        if (m0_cyc_i) begin
                            state    <= GNT0;
                            last_gnt <= 1'b0;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_wb_sdram_arbiter.sv
// ---------------------------------------------------------------------------
// tb_wb_sdram_arbiter
//
// Self-checking bench for wb_sdram_arbiter. Each master task pushes every
// beat it presents into that master's expectation queue. A zero-wait-state
// slave model acks on the falling edge. A monitor pops the expectation for
// the acknowledged master and compares the slave-side fields and read data.
// Directed sequences check latency, handover gap, grant order, burst
// integrity, read routing and reset behaviour.
// ---------------------------------------------------------------------------
module tb_wb_sdram_arbiter;

    localparam int DW = 32;
    localparam int AW = 26;

    typedef struct {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] dat;   // write data, or expected read data
        logic [3:0]    sel;
        logic [2:0]    cti;
    } beat_t;

    logic sys_clk = 1'b0;
    logic sys_rst = 1'b1;
    always #5 sys_clk = ~sys_clk;

    logic          m_cyc [2];
    logic          m_stb [2];
    logic          m_we  [2];
    logic [AW-1:0] m_addr[2];
    logic [DW-1:0] m_dat [2];
    logic [3:0]    m_sel [2];
    logic [2:0]    m_cti [2];

    logic          m0_ack_o, m0_err_o, m1_ack_o, m1_err_o;
    logic [DW-1:0] m0_dat_o, m1_dat_o;
    logic          s_cyc_o, s_stb_o, s_we_o;
    logic [AW-1:0] s_addr_o;
    logic [DW-1:0] s_dat_o;
    logic [3:0]    s_sel_o;
    logic [2:0]    s_cti_o;
    logic          s_ack_i;
    logic [DW-1:0] s_dat_i;
    logic [1:0]    gnt_o;

    wb_sdram_arbiter #(.dw(DW), .aw(AW), .TIMEOUT(16)) dut (
        .sys_clk  (sys_clk),
        .sys_rst  (sys_rst),
        .m0_cyc_i (m_cyc[0]), .m0_stb_i (m_stb[0]), .m0_we_i (m_we[0]),
        .m0_addr_i(m_addr[0]), .m0_dat_i(m_dat[0]), .m0_sel_i(m_sel[0]),
        .m0_cti_i (m_cti[0]), .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o),
        .m0_dat_o (m0_dat_o),
        .m1_cyc_i (m_cyc[1]), .m1_stb_i (m_stb[1]), .m1_we_i (m_we[1]),
        .m1_addr_i(m_addr[1]), .m1_dat_i(m_dat[1]), .m1_sel_i(m_sel[1]),
        .m1_cti_i (m_cti[1]), .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o),
        .m1_dat_o (m1_dat_o),
        .s_cyc_o  (s_cyc_o), .s_stb_o (s_stb_o), .s_we_o (s_we_o),
        .s_addr_o (s_addr_o), .s_dat_o (s_dat_o), .s_sel_o (s_sel_o),
        .s_cti_o  (s_cti_o), .s_ack_i (s_ack_i), .s_dat_i (s_dat_i),
        .gnt_o    (gnt_o)
    );

    int         vectors     = 0;
    int         miscompares = 0;
    beat_t      q0[$];
    beat_t      q1[$];
    int         owner_log[$];
    logic [1:0] tr_gnt[$];
    logic       tr_cyc[$];
    bit         rec       = 1'b0;
    bit         ack_en    = 1'b1;
    bit         abort     = 1'b0;
    int         beats_done[2] = '{0, 0};
    logic [DW-1:0] last_rd1 = '0;
    beat_t      mon_e;
    int         mon_owner;
    logic [DW-1:0] mon_rd;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Slave memory contents as seen by reads: address 0x40 returns 0x12345678.
    function automatic logic [DW-1:0] rdata(input logic [AW-1:0] a);
        return 32'h1234_5638 ^ {6'b0, a};
    endfunction

    function automatic logic get_ack(input int m);
        return (m == 1) ? m1_ack_o : m0_ack_o;
    endfunction

    // The owner log packed into bits, with the oldest owner in the MSB.
    function automatic logic [63:0] log_code();
        logic [63:0] c = '0;
        foreach (owner_log[i]) c = {c[62:0], (owner_log[i] != 0)};
        return c;
    endfunction

    // Zero-wait-state slave: acks any strobed cycle on the falling edge.
    initial begin
        s_ack_i = 1'b0;
        s_dat_i = '0;
        forever begin
            @(negedge sys_clk);
            s_ack_i = ack_en && s_cyc_o && s_stb_o;
            s_dat_i = rdata(s_addr_o);
        end
    end

    // Monitor: compare each acknowledged beat against the expectation queue.
    initial begin
        forever begin
            @(negedge sys_clk);
            #2;
            if (rec) begin
                tr_gnt.push_back(gnt_o);
                tr_cyc.push_back(s_cyc_o);
            end
            if (s_ack_i && !sys_rst) begin
                check("ack_onehot", 64'(m0_ack_o ^ m1_ack_o), 64'd1);
                mon_owner = m1_ack_o ? 1 : 0;
                owner_log.push_back(mon_owner);
                check("sb_nonempty", 64'((mon_owner == 1) ? q1.size() > 0 : q0.size() > 0), 64'd1);
                if ((mon_owner == 1) ? q1.size() > 0 : q0.size() > 0) begin
                    mon_e = (mon_owner == 1) ? q1.pop_front() : q0.pop_front();
                    check("s_we", s_we_o, mon_e.we);
                    check("s_addr", s_addr_o, mon_e.addr);
                    check("s_sel", s_sel_o, mon_e.sel);
                    check("s_cti", s_cti_o, mon_e.cti);
                    if (mon_e.we) begin
                        check("s_dat", s_dat_o, mon_e.dat);
                    end else begin
                        mon_rd = (mon_owner == 1) ? m1_dat_o : m0_dat_o;
                        check("rd_dat", mon_rd, mon_e.dat);
                        if (mon_owner == 1) last_rd1 = mon_rd;
                    end
                end
            end
        end
    end

    // Master m runs an n-beat cycle: single classic when n == 1, otherwise an
    // incrementing burst that ends with cti 111.
    task automatic master_run(input int m, input int n, input logic we,
                              input logic [AW-1:0] base, input logic [DW-1:0] dbase);
        beat_t e;
        bit    got;
        for (int b = 0; b < n && !abort; b++) begin
            e.we   = we;
            e.addr = base + AW'(b);
            e.dat  = we ? dbase + DW'(b) : rdata(e.addr);
            e.sel  = 4'hF;
            e.cti  = (n == 1) ? 3'b000 : ((b == n - 1) ? 3'b111 : 3'b010);
            m_cyc[m]  = 1'b1;
            m_stb[m]  = 1'b1;
            m_we[m]   = we;
            m_addr[m] = e.addr;
            m_dat[m]  = we ? e.dat : '0;
            m_sel[m]  = e.sel;
            m_cti[m]  = e.cti;
            if (m == 1) q1.push_back(e); else q0.push_back(e);
            got = 1'b0;
            for (int t = 0; t < 200 && !got && !abort; t++) begin
                @(negedge sys_clk);
                #1;
                if (get_ack(m)) got = 1'b1;
                else @(posedge sys_clk);
            end
            if (!abort) check($sformatf("m%0d_ack_seen", m), 64'(got), 64'd1);
            if (got) begin
                beats_done[m]++;
                @(posedge sys_clk);
                #1;
            end
        end
        m_cyc[m]  = 1'b0;
        m_stb[m]  = 1'b0;
        m_we[m]   = 1'b0;
        m_addr[m] = '0;
        m_dat[m]  = '0;
        m_sel[m]  = '0;
        m_cti[m]  = '0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge sys_clk);
        #1;
    endtask

    task automatic do_reset();
        sys_rst = 1'b1;
        q0.delete();
        q1.delete();
        owner_log.delete();
        repeat (2) @(posedge sys_clk);
        #1;
        sys_rst = 1'b0;
    endtask

    // Returns at posedge+2 once master m has completed k more beats.
    task automatic wait_beats(input int m, input int k);
        int start = beats_done[m];
        for (int i = 0; i < 200; i++) begin
            @(posedge sys_clk);
            #2;
            if (beats_done[m] - start >= k) break;
        end
        check("beats_reached", 64'(beats_done[m] - start >= k), 64'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int last0;
        int first1;
`ifdef WB_ARB_TIMEOUT_EN
        int stall;
        bit err_seen;
`endif
        for (int i = 0; i < 2; i++) begin
            m_cyc[i] = 1'b0; m_stb[i] = 1'b0; m_we[i] = 1'b0;
            m_addr[i] = '0; m_dat[i] = '0; m_sel[i] = '0; m_cti[i] = '0;
        end

        // Reset state, with a request already pending from m0.
        m_cyc[0] = 1'b1; m_stb[0] = 1'b1; m_we[0] = 1'b1;
        m_addr[0] = 26'h3FF; m_dat[0] = '1; m_sel[0] = 4'hF;
        repeat (2) begin @(negedge sys_clk); #1; end
        check("rst_gnt", gnt_o, 2'b00);
        check("rst_cyc", s_cyc_o, 1'b0);
        check("rst_stb", s_stb_o, 1'b0);
        check("rst_we", s_we_o, 1'b0);
        check("rst_addr", s_addr_o, '0);
        check("rst_dat", s_dat_o, '0);
        check("rst_sel", s_sel_o, '0);
        check("rst_m0_ack", m0_ack_o, 1'b0);
        check("rst_m0_err", m0_err_o, 1'b0);
        check("rst_m1_err", m1_err_o, 1'b0);
        m_cyc[0] = 1'b0; m_stb[0] = 1'b0; m_we[0] = 1'b0;
        m_addr[0] = '0; m_dat[0] = '0; m_sel[0] = '0;
        @(posedge sys_clk);
        #1;
        sys_rst = 1'b0;

        // Single write from m0, with the slave stalled so latency is visible.
        @(posedge sys_clk);
        #1;
        ack_en = 1'b0;
        fork
            master_run(0, 1, 1'b1, 26'h000100, 32'hDEADBEEF);
        join_none
        @(negedge sys_clk); #1;
        check("lat_pre_cyc", s_cyc_o, 1'b0);
        @(negedge sys_clk); #1;
        check("lat_cyc", s_cyc_o, 1'b1);
        check("lat_gnt", gnt_o, 2'b01);
        check("lat_addr", s_addr_o, 26'h000100);
        check("lat_dat", s_dat_o, 32'hDEADBEEF);
        check("lat_sel", s_sel_o, 4'hF);
        check("lat_m1_ack", m1_ack_o, 1'b0);
        ack_en = 1'b1;
        wait fork;
        check("t1_len", owner_log.size(), 1);
        check("t1_order", log_code(), 64'b0);

        // Simultaneous requests after reset: m0 first, one idle cycle, then m1.
        idle(2);
        do_reset();
        tr_gnt.delete();
        tr_cyc.delete();
        rec = 1'b1;
        fork
            master_run(0, 1, 1'b1, 26'h10, 32'hA0);
            master_run(1, 1, 1'b1, 26'h11, 32'hB0);
        join
        idle(2);
        rec = 1'b0;
        check("t2_len", owner_log.size(), 2);
        check("t2_order", log_code(), 64'b01);
        last0  = -1;
        first1 = -1;
        foreach (tr_gnt[i]) begin
            if (tr_gnt[i] == 2'b01 && tr_cyc[i]) last0 = i;
            if (tr_gnt[i] == 2'b10 && tr_cyc[i] && first1 < 0) first1 = i;
        end
        check("handover_gap", 64'(first1 - last0 - 1), 64'd1);

        // Second contention: last_gnt is m1, so m0 wins again.
        owner_log.delete();
        fork
            master_run(0, 1, 1'b1, 26'h12, 32'hC0);
            master_run(1, 1, 1'b1, 26'h13, 32'hD0);
        join
        check("t2b_order", log_code(), 64'b01);

        // Eight-beat burst from m1; m0 requests partway through.
        idle(2);
        owner_log.delete();
        fork
            master_run(1, 8, 1'b1, 26'h20, 32'h100);
            begin
                wait_beats(1, 3);
                master_run(0, 1, 1'b1, 26'h30, 32'h200);
            end
        join
        check("burst_len", owner_log.size(), 9);
        check("burst_order", log_code(), 64'h1FE);

        // Read from m1: controller data is routed to m1 only.
        idle(2);
        owner_log.delete();
        master_run(1, 1, 1'b0, 26'h40, '0);
        check("rd_len", owner_log.size(), 1);
        check("rd_owner", log_code(), 64'b1);
        check("rd_value", last_rd1, 32'h12345678);

        // Reset on beat 4 of an m0 burst: the bus drops at once.
        idle(2);
        fork
            master_run(0, 8, 1'b1, 26'h50, 32'h300);
        join_none
        wait_beats(0, 3);
        sys_rst = 1'b1;
        #1;
        check("mid_rst_cyc", s_cyc_o, 1'b0);
        check("mid_rst_stb", s_stb_o, 1'b0);
        check("mid_rst_gnt", gnt_o, 2'b00);
        check("mid_rst_ack", m0_ack_o, 1'b0);
        abort = 1'b1;
        wait fork;
        abort = 1'b0;
        do_reset();
        fork
            master_run(0, 1, 1'b1, 26'h60, 32'h400);
            master_run(1, 1, 1'b1, 26'h61, 32'h500);
        join
        check("post_rst_len", owner_log.size(), 2);
        check("post_rst_order", log_code(), 64'b01);

`ifdef WB_ARB_TIMEOUT_EN
        // The controller never acks m0: err on the 16th stalled cycle, then m1.
        idle(2);
        do_reset();
        ack_en = 1'b0;
        m_cyc[0] = 1'b1; m_stb[0] = 1'b1; m_addr[0] = 26'h70;
        m_cyc[1] = 1'b1; m_stb[1] = 1'b1; m_addr[1] = 26'h71;
        stall    = 0;
        err_seen = 1'b0;
        for (int i = 0; i < 40 && !err_seen; i++) begin
            @(negedge sys_clk);
            #1;
            if (gnt_o == 2'b01 && s_stb_o) stall++;
            if (m0_err_o) err_seen = 1'b1;
        end
        check("to_stall_cycles", 64'(stall), 64'd16);
        @(posedge sys_clk);
        #1;
        check("to_idle", gnt_o, 2'b00);
        check("to_err_pulse", m0_err_o, 1'b0);
        m_cyc[0] = 1'b0; m_stb[0] = 1'b0; m_addr[0] = '0;
        @(posedge sys_clk);
        #1;
        check("to_m1_gnt", gnt_o, 2'b10);
        m_cyc[1] = 1'b0; m_stb[1] = 1'b0; m_addr[1] = '0;
        ack_en = 1'b1;
`endif

        idle(3);
        check("sb_drain", 64'(q0.size() + q1.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
